// File: rtl/uart_mon_pkg.sv
// Shared types and constants for the UART receive monitor.
//   state_t   : receiver FSM states
//   DATA_BITS : payload bits per 8N1 frame
package uart_mon_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

endpackage

// File: rtl/uart_mon_fifo.sv
// Synchronous byte FIFO with a registered head byte (no fall-through).
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   push, din     : write request and byte
//   pop           : read request, ignored while empty
//   dout          : registered head byte
//   full, empty   : registered status flags
//   level         : registered occupancy
//   level_next_c  : occupancy after this cycle's push/pop (combinational)
module uart_mon_fifo
   import uart_mon_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DATA_BITS-1:0]   din,
   input  logic                   pop,
   output logic [DATA_BITS-1:0]   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic [$clog2(DEPTH):0] level_next_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, wr_ptr_next;
   logic [PTR_W-1:0]     rd_ptr, rd_ptr_next;
   logic [DATA_BITS-1:0] dout_next;
   logic                 push_ok, pop_ok;

   // Accept a push when full only if a pop frees a slot in the same cycle.
   always_comb begin
      pop_ok       = pop && !empty;
      push_ok      = push && (!full || pop_ok);
      wr_ptr_next  = wr_ptr + PTR_W'(push_ok);
      rd_ptr_next  = rd_ptr + PTR_W'(pop_ok);
      level_next_c = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
      dout_next    = dout;
      // New head is the incoming byte when it lands on the next read slot.
      if (level_next_c != '0) begin
         if (push_ok && (wr_ptr == rd_ptr_next)) begin
            dout_next = din;
         end else begin
            dout_next = mem[rd_ptr_next];
         end
      end
   end

   // Pointer, occupancy and head registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         level  <= level_next_c;
         full   <= (level_next_c == LVL_W'(DEPTH));
         empty  <= (level_next_c == '0);
         dout   <= dout_next;
      end
   end

   // Storage array.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receive monitor: decodes the SoC uartStd_txd stream, buffers
// bytes in a FIFO and throttles the SoC through uartStd_cts.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   rxd          : serial line from the SoC, idle high
//   cts          : 1 = SoC must hold off (FIFO level >= DEPTH-2)
//   data, valid  : FIFO head byte and non-empty flag
//   ready        : consumer pop, taken when valid && ready
//   frame_error  : one-cycle pulse on a bad stop bit
//   overflow     : sticky, a byte was dropped on a full FIFO
//   level        : FIFO occupancy
module uart_rx_monitor
   import uart_mon_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rxd,
   output logic                   cts,
   output logic [DATA_BITS-1:0]   data,
   output logic                   valid,
   input  logic                   ready,
   output logic                   frame_error,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [LVL_W-1:0] CTS_LVL  = LVL_W'(DEPTH - 2);

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [IDX_W-1:0]     idx, idx_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic                 rxd_m, rxd_s;
   logic                 fe_next, ovf_next, cts_next, valid_next;
   logic                 push_c, pop_c;
   logic                 fifo_full, fifo_empty;
   logic [LVL_W-1:0]     level_next_c;

   // Receiver FSM next-state, datapath and flag logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      shift_next = shift;
      fe_next    = 1'b0;
      push_c     = 1'b0;

      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         // Re-check the line mid start bit to reject glitches.
         START: begin
            if (cnt == CNT_HALF) begin
               if (rxd_s) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  cnt_next   = '0;
                  idx_next   = '0;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         // Bits arrive LSB first, so shift in from the top.
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_next   = '0;
               shift_next = {rxd_s, shift[DATA_BITS-1:1]};
               if (idx == IDX_LAST) begin
                  state_next = STOP;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               if (rxd_s) begin
                  push_c     = 1'b1;
                  state_next = IDLE;
               end else begin
                  fe_next    = 1'b1;
                  state_next = BREAK;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         // Wait out a held-low line before hunting for the next start bit.
         BREAK: begin
            if (rxd_s) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      pop_c      = ready && valid;
      ovf_next   = overflow || (push_c && fifo_full && !pop_c);
      cts_next   = (level_next_c >= CTS_LVL);
      valid_next = (level_next_c != '0);
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shift       <= '0;
         rxd_m       <= 1'b1;
         rxd_s       <= 1'b1;
         frame_error <= 1'b0;
         overflow    <= 1'b0;
         cts         <= 1'b0;
         valid       <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         idx         <= idx_next;
         shift       <= shift_next;
         rxd_m       <= rxd;
         rxd_s       <= rxd_m;
         frame_error <= fe_next;
         overflow    <= ovf_next;
         cts         <= cts_next;
         valid       <= valid_next;
      end
   end

   uart_mon_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push         (push_c),
      .din          (shift),
      .pop          (pop_c),
      .dout         (data),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .level        (level),
      .level_next_c (level_next_c)
   );

   // The registered valid mirrors the FIFO's own empty flag.
   logic unused_empty;
   assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed self-checking bench for uart_rx_monitor (CLKS_PER_BIT=8, DEPTH=8).
module tb_uart_rx_monitor;

   logic       clock;
   logic       reset;
   logic       rxd;
   logic       cts;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_error;
   logic       overflow;
   logic [3:0] level;

   int checks  = 0;
   int errors  = 0;
   int fe_count = 0;
   int rise_at;

   uart_rx_monitor #(
      .CLKS_PER_BIT (8),
      .DEPTH        (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rxd         (rxd),
      .cts         (cts),
      .data        (data),
      .valid       (valid),
      .ready       (ready),
      .frame_error (frame_error),
      .overflow    (overflow),
      .level       (level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (frame_error) fe_count <= fe_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one frame, one line value per negedge; optionally pulse ready in
   // the stop-sample cycle. Records the cycle index where valid first rises.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int stop_cycles, input logic pop_stop);
      logic [9:0] bits;
      logic       prev;
      bits    = {stop, b, 1'b0};
      rise_at = -1;
      prev    = valid;
      for (int n = 0; n < 72 + stop_cycles; n++) begin
         rxd = (n < 72) ? bits[n/8] : stop;
         if (pop_stop) ready = (n == 78);
         @(negedge clock);
         if (valid && !prev && rise_at < 0) rise_at = n + 1;
         prev = valid;
      end
      rxd   = 1'b1;
      ready = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic pop_one(input logic [7:0] exp_data, input int exp_level);
      check("pop_valid", 32'(valid), 32'd1);
      check("pop_data", 32'(data), 32'(exp_data));
      ready = 1'b1;
      @(negedge clock);
      ready = 1'b0;
      check("pop_level", 32'(level), 32'(exp_level));
      check("pop_cts", 32'(cts), (exp_level >= 6) ? 32'd1 : 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cts"},   32'(cts),         32'd0);
      check({tag, "_valid"}, 32'(valid),       32'd0);
      check({tag, "_data"},  32'(data),        32'd0);
      check({tag, "_fe"},    32'(frame_error), 32'd0);
      check({tag, "_ovf"},   32'(overflow),    32'd0);
      check({tag, "_level"}, 32'(level),       32'd0);
   endtask

   initial begin
      int fe_before;
      int lv;
      logic [9:0] pbits;

      reset = 1'b1;
      rxd   = 1'b1;
      ready = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // Single frame: valid one cycle after the stop sample (cycle 79).
      send_frame(8'h55, 1'b1, 8, 1'b0);
      check("single_rise", 32'(rise_at), 32'd79);
      check("single_data", 32'(data), 32'h55);
      check("single_level", 32'(level), 32'd1);
      check("single_no_fe", 32'(fe_count), 32'd0);
      pop_one(8'h55, 0);
      check("single_empty", 32'(valid), 32'd0);

      // Glitch shorter than half a bit is rejected.
      rxd = 1'b0;
      repeat (2) @(negedge clock);
      rxd = 1'b1;
      repeat (12) @(negedge clock);
      check("glitch_level", 32'(level), 32'd0);
      check("glitch_valid", 32'(valid), 32'd0);

      // Bad stop bit held low for three bit times.
      fe_before = fe_count;
      send_frame(8'hA3, 1'b0, 24, 1'b0);
      check("ferr_pulses", 32'(fe_count - fe_before), 32'd1);
      check("ferr_level", 32'(level), 32'd0);
      send_frame(8'h3C, 1'b1, 8, 1'b0);
      check("after_ferr_data", 32'(data), 32'h3C);
      check("after_ferr_level", 32'(level), 32'd1);
      pop_one(8'h3C, 0);

      // Fill past full with no consumer.
      for (int k = 1; k <= 9; k++) begin
         send_frame(8'(k), 1'b1, 8, 1'b0);
         lv = (k > 8) ? 8 : k;
         check("fill_level", 32'(level), 32'(lv));
         check("fill_cts", 32'(cts), (lv >= 6) ? 32'd1 : 32'd0);
         check("fill_ovf", 32'(overflow), (k == 9) ? 32'd1 : 32'd0);
      end
      for (int k = 1; k <= 8; k++) begin
         pop_one(8'(k), 8 - k);
      end
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Reset during data bit 4 with a byte buffered and overflow set.
      send_frame(8'h5A, 1'b1, 8, 1'b0);
      check("pre_rst_level", 32'(level), 32'd1);
      pbits = {1'b1, 8'hAB, 1'b0};
      for (int n = 0; n < 40; n++) begin
         rxd = pbits[n/8];
         @(negedge clock);
      end
      reset = 1'b1;
      rxd   = 1'b1;
      repeat (2) @(negedge clock);
      check_reset_outputs("midrst");
      reset = 1'b0;
      repeat (4) @(negedge clock);
      send_frame(8'hF0, 1'b1, 8, 1'b0);
      check("post_rst_data", 32'(data), 32'hF0);
      check("post_rst_level", 32'(level), 32'd1);
      pop_one(8'hF0, 0);

      // Push and pop together while full.
      for (int k = 0; k < 8; k++) begin
         send_frame(8'(8'h10 + k), 1'b1, 8, 1'b0);
      end
      check("full_level", 32'(level), 32'd8);
      send_frame(8'h77, 1'b1, 8, 1'b1);
      check("pp_level", 32'(level), 32'd8);
      check("pp_ovf", 32'(overflow), 32'd0);
      check("pp_cts", 32'(cts), 32'd1);
      for (int k = 1; k < 8; k++) begin
         pop_one(8'(8'h10 + k), 8 - k);
      end
      pop_one(8'h77, 0);
      check("pp_final_valid", 32'(valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

UART receive monitor for the ElemRV SoC simulation environment. It sits directly downstream of the SoC's standard UART pads: it consumes the serial `uartStd_txd` stream, decodes 8N1 frames and buffers the bytes in a small FIFO. It drives the SoC's `uartStd_cts` pad to throttle the transmitter when the FIFO nears full, and presents bytes on a valid/ready port for a checker or console printer.

## Interface
Parameters:
- CLKS_PER_BIT, 217: clock cycles per UART bit (25 MHz / 115200). Minimum 4.
- DEPTH, 8: FIFO depth in bytes. Power of two, at least 4.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- rxd  in  1  serial data from the SoC `uartStd_txd` pad. Idle high.
- cts  out  1  to the SoC `uartStd_cts` pad. 0 = SoC may send; 1 = hold off.
- data  out  8  FIFO head byte.
- valid  out  1  FIFO non-empty.
- ready  in  1  consumer pop; a pop occurs when valid && ready.
- frame_error  out  1  one-cycle pulse on a bad stop bit.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- `rxd` passes through a 2-flop synchronizer, reset value 1. Every reference to the line below means the synchronized value `rxd_s`.
- The FSM has five states: IDLE, START, DATA, STOP, BREAK. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) run alongside it.
- IDLE: `rxd_s`==0 → START, bit counter cleared.
- START: at count CLKS_PER_BIT/2-1 (integer division), sample the line.
  - Sample 1: false start, → IDLE.
  - Sample 0: → DATA, counter cleared.
- DATA: each time the count reaches CLKS_PER_BIT-1, sample one bit into a shift register, LSB first. After bit 7 → STOP.
- STOP: sample at count CLKS_PER_BIT-1.
  - Sample 1: push the byte, → IDLE.
  - Sample 0: pulse frame_error, no push, → BREAK.
- BREAK: stay until `rxd_s`==1, then → IDLE.
- FIFO:
  - Push when full: byte dropped, overflow set.
  - Push and pop in the same cycle while full: both occur; the byte is accepted and level is unchanged.
  - Pop when empty is impossible because valid=0.
  - level wraps nowhere; pointers wrap modulo DEPTH.
- cts: registered, equal to (level ≥ DEPTH-2), evaluated from the next-state level.
- overflow: clears only on reset.

## Timing
- Reset values: cts=0, valid=0, data=0, frame_error=0, overflow=0, level=0. FSM in IDLE.
- Falling edge on `rxd` to START entry: 3 cycles (2 synchronizer + 1).
- Stop-bit sample to valid=1 on an empty FIFO: 1 cycle. There is no fall-through.
- Pop: data and level update on the cycle after the valid && ready edge.
- cts changes on the same edge that level changes.
- frame_error is high for exactly 1 cycle.
- Reset asserted mid-frame: FSM → IDLE, partial byte discarded, FIFO emptied, overflow cleared. A line still low after reset is treated as a new start.

## Structure
- Package `uart_mon_pkg`:
  - FSM state enum.
  - DATA_BITS=8.
- Sub-module `uart_mon_fifo`: synchronous FIFO with push, pop, full, empty and level.
- The FSM, synchronizer and cts logic stay in the top module.
- The block is instantiated in the SoC top-level bench, with rxd connected to the SoC `uartStd_txd` pad and cts connected to the SoC `uartStd_cts` pad.

## Test plan
All scenarios use CLKS_PER_BIT=8 and DEPTH=8.
- Single frame: send 0x55 with a valid stop bit → valid=1 with data=0x55 one cycle after the stop sample; level=1; frame_error never pulses.
- Glitch: hold rxd low for 2 cycles, then high → no byte, FSM returns to IDLE, level=0.
- Frame error: send 0xA3 with stop bit 0, release the line after 3 bit times → one frame_error pulse, level=0. Then send 0x3C → data=0x3C.
- Overflow and flow control: send 0x01..0x09 with ready=0 → cts=1 after the 6th byte. The 9th byte is dropped, overflow=1, level=8. Popping yields 0x01..0x08 in order, and cts returns to 0 when level drops to 5.
- Full push/pop: with FIFO full, hold ready=1 exactly on the stop-sample cycle of byte 0x77 → level stays 8, no overflow, 0x77 is last out.
- Reset mid-frame: assert reset during DATA bit 4 → all outputs return to reset values. The next clean frame 0xF0 is received correctly.
